// File: rtl/botao_pedestre_pkg.sv
// botao_pedestre_pkg: shared enums and constants for the pedestrian button path.
package semaforo_pkg;
    typedef enum logic [1:0] {R_IDLE, R_PEND, R_COOL} req_state_e;
    typedef enum logic {D_STABLE, D_COUNT} deb_state_e;
    localparam logic [2:0] VERDE    = 3'b100;
    localparam logic [2:0] AMARELO  = 3'b010;
    localparam logic [2:0] VERMELHO = 3'b001;
    localparam int CNT_W = 8;
endpackage

// File: rtl/botao_pedestre_if.sv
// botao_pedestre_if: button/request signals between the conditioner and its user.
interface botao_pedestre_if;
    logic bt_raw;
    logic ack;
    logic bt_clean;
    logic req;
    logic busy;
    logic [semaforo_pkg::CNT_W-1:0] press_cnt;
    modport master(output bt_raw, ack, input bt_clean, req, busy, press_cnt);
    modport slave(input bt_raw, ack, output bt_clean, req, busy, press_cnt);
endinterface

// File: rtl/botao_pedestre_debounce_bt.sv
// debounce_bt: synchronizes the raw button and accepts a level only after it
// has disagreed with the stable level for more than DEBOUNCE_CYCLES samples.
module debounce_bt
    import semaforo_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic bt_raw_i,
    output logic bt_clean_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0] cnt_q, cnt_d;
    deb_state_e st_q, st_d;
    logic level_q, level_d, bt_sync, differ, done;
    assign bt_sync = sync_q[SYNC_STAGES-1];
    always_comb begin
        differ  = bt_sync != level_q;
        done    = st_q == D_COUNT && cnt_q == DW'(DEBOUNCE_CYCLES);
        st_d    = differ && !done ? D_COUNT : D_STABLE;
        cnt_d   = differ && !done ? cnt_q + DW'(1) : '0;
        level_d = differ && done ? ~level_q : level_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            st_q    <= D_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bt_raw_i};
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
    assign bt_clean_o = level_q;
endmodule

// File: rtl/botao_pedestre.sv
// botao_pedestre: debounced pedestrian button turned into a held, acknowledged request.
// Optional post-acknowledge lockout built when SEMAFORO_COOLDOWN_EN is defined.
module botao_pedestre
    import semaforo_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 64
) (
    input logic clk,
    input logic rst,
    botao_pedestre_if.slave bus
);
    req_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic bt_clean, clean_prev_q, press;
    debounce_bt #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk(clk), .rst(rst), .bt_raw_i(bus.bt_raw), .bt_clean_o(bt_clean)
    );
    assign press = bt_clean & ~clean_prev_q;
`ifdef SEMAFORO_COOLDOWN_EN
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam req_state_e AFTER_ACK = R_COOL;
    logic [CW-1:0] cool_q, cool_d;
    // cool_q counts the remaining lockout cycles after the acknowledge edge
    always_comb begin
        cool_d = state_q == R_PEND && bus.ack ? CW'(COOLDOWN_CYCLES - 1)
               : state_q == R_COOL && cool_q != '0 ? cool_q - CW'(1) : cool_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cool_q <= '0;
        else cool_q <= cool_d;
    end
    assign bus.busy = state_q == R_COOL;
`else
    localparam req_state_e AFTER_ACK = R_IDLE;
    // constant 0; the comparison only keeps the lockout length referenced
    assign bus.busy = COOLDOWN_CYCLES < 0;
`endif
    always_comb begin
        state_d = state_q;
        if (state_q == R_IDLE && press) state_d = R_PEND;
        if (state_q == R_PEND && bus.ack) state_d = AFTER_ACK;
`ifdef SEMAFORO_COOLDOWN_EN
        if (state_q == R_COOL && cool_q == '0) state_d = R_IDLE;
`endif
        cnt_d = state_q == R_IDLE && press && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= R_IDLE;
            cnt_q        <= '0;
            clean_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clean_prev_q <= bt_clean;
        end
    end
    assign bus.bt_clean  = bt_clean;
    assign bus.req       = state_q == R_PEND;
    assign bus.press_cnt = cnt_q;
endmodule

// File: tb/tb_botao_pedestre.sv
// tb_botao_pedestre: random and directed stimulus checked every cycle against a behavioural model.
module tb_botao_pedestre;
    import semaforo_pkg::*;
    localparam int S = 2, D = 4, C = 8;
`ifdef SEMAFORO_COOLDOWN_EN
    localparam bit COOL_EN = 1'b1;
`else
    localparam bit COOL_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    botao_pedestre_if bus();
    botao_pedestre #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    typedef struct packed {
        logic [S-1:0] sh;
        logic level;
        logic [7:0] run;
        logic prev;
        logic req;
        logic [7:0] cool;
        logic [7:0] cnt;
    } model_t;
    model_t m;
    // level flips once the synchronized input disagrees on D+1 samples in a row
    function automatic model_t step(model_t cur, logic raw, logic a);
        model_t n = cur;
        logic sync = cur.sh[S-1];
        logic pr = cur.level & ~cur.prev;
        logic [7:0] r = (sync != cur.level) ? cur.run + 8'd1 : 8'd0;
        n.sh = {cur.sh[S-2:0], raw};
        n.prev = cur.level;
        if (r == 8'(D + 1)) begin
            n.level = ~cur.level;
            n.run = 8'd0;
        end else n.run = r;
        if (cur.cool != 0) n.cool = cur.cool - 8'd1;
        if (cur.req && a) begin
            n.req = 1'b0;
            n.cool = COOL_EN ? 8'(C) : 8'd0;
        end else if (!cur.req && cur.cool == 0 && pr) begin
            n.req = 1'b1;
            n.cnt = cur.cnt == 8'd255 ? 8'd255 : cur.cnt + 8'd1;
        end
        return n;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else m <= step(m, bus.bt_raw, bus.ack);
    end
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask
    always @(negedge clk) begin
        if (rst) begin
            chk("bt_clean", 32'(bus.bt_clean), 32'(m.level));
            chk("req", 32'(bus.req), 32'(m.req));
            chk("busy", 32'(bus.busy), 32'(m.cool != 0));
            chk("press_cnt", 32'(bus.press_cnt), 32'(m.cnt));
        end
    end
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic ack_pulse();
        bus.ack = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
    endtask
    task automatic press(int hold, int rel);
        bus.bt_raw = 1'b1;
        cyc(hold);
        bus.bt_raw = 1'b0;
        cyc(rel);
    endtask
    initial begin
        int nb;
        bit seen;
        bus.bt_raw = 1'b1;
        bus.ack = 1'b0;
        cyc(3);
        chk("rst_clean", 32'(bus.bt_clean), 0);
        chk("rst_req", 32'(bus.req), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cnt", 32'(bus.press_cnt), 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) chk("edge5_clean", 32'(bus.bt_clean), 0);
            if (i == 6) begin
                chk("edge6_clean", 32'(bus.bt_clean), 1);
                chk("edge6_req", 32'(bus.req), 0);
            end
            if (i == 7) begin
                chk("edge7_req", 32'(bus.req), 1);
                chk("edge7_cnt", 32'(bus.press_cnt), 1);
            end
        end
        @(negedge clk);
        bus.bt_raw = 1'b0;
        cyc(10);
        press(10, 10);
        chk("merge_req", 32'(bus.req), 1);
        chk("merge_cnt", 32'(bus.press_cnt), 1);
        bus.ack = 1'b1;
        if (COOL_EN) bus.bt_raw = 1'b1;
        cyc(1);
        bus.ack = 1'b0;
        chk("ack_req", 32'(bus.req), 0);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) nb++;
            cyc(1);
        end
        bus.bt_raw = 1'b0;
        chk("busy_len", 32'(nb), COOL_EN ? C : 0);
        chk("cool_press_req", 32'(bus.req), 0);
        cyc(10);
        press(8, 10);
        chk("post_cool_req", 32'(bus.req), 1);
        chk("post_cool_cnt", 32'(bus.press_cnt), 2);
        bus.bt_raw = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1);
            seen = bus.bt_clean;
        end
        chk("coll_clean_seen", 32'(seen), 1);
        ack_pulse();
        chk("coll_req", 32'(bus.req), 0);
        chk("coll_cnt", 32'(bus.press_cnt), 2);
        bus.bt_raw = 1'b0;
        cyc(C + 10);
        ack_pulse();
        chk("idle_ack_req", 32'(bus.req), 0);
        chk("idle_ack_busy", 32'(bus.busy), 0);
        for (int s = 0; s < 300; s++) begin
            bus.bt_raw = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(1, 10); k > 0; k--) begin
                bus.ack = m.req && $urandom_range(0, 3) == 0;
                cyc(1);
            end
        end
        bus.ack = 1'b0;
        bus.bt_raw = 1'b0;
        cyc(C + 10);
        for (int s = 0; s < 260; s++) begin
            press(7, 7);
            ack_pulse();
            cyc(C + 2);
        end
        chk("sat_cnt", 32'(bus.press_cnt), 255);
        press(8, 3);
        chk("pre_rst_req", 32'(bus.req), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(bus.req), 0);
        chk("arst_clean", 32'(bus.bt_clean), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_cnt", 32'(bus.press_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        press(8, 10);
        chk("after_rst_cnt", 32'(bus.press_cnt), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/botao_pedestre.md
# botao_pedestre

Pedestrian push-button conditioner that sits directly upstream of the traffic-light controller and drives its button request input. It synchronizes the raw asynchronous button, debounces it, converts each clean press into a held request, and clears that request only on an acknowledge from the controller. An optional cooldown window then suppresses repeat presses.

## Interface
- SYNC_STAGES, 2: flip-flops in the input synchronizer chain; legal range ≥ 2.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a level change; legal range ≥ 1.
- COOLDOWN_CYCLES, 64: post-acknowledge lockout length; used only with the cooldown feature.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- bt_raw  input  1  raw push-button level, asynchronous, bouncy; 1 = pressed.
- ack  input  1  single-cycle pulse from the controller; accepts the pending request.
- bt_clean  output  1  debounced button level.
- req  output  1  pending pedestrian request; held high until acknowledged.
- busy  output  1  high while the cooldown lockout is active.
- press_cnt  output  8  saturating count of accepted presses.

## Operation
- Reset (rst low, asynchronous) values:
  - all outputs 0;
  - synchronizer chain 0, debounce counter 0, stable level 0;
  - request FSM in R_IDLE.
- Synchronizer: bt_raw passes through SYNC_STAGES flops to produce bt_sync.
- Debounce FSM (module debounce_bt) tracks a stable level held on bt_clean.
  - When bt_sync differs from the stable level, the counter increments.
  - When bt_sync equals the stable level, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - The counter width is clog2(DEBOUNCE_CYCLES+1), and the counter never wraps.
- Press event: a 0→1 transition of bt_clean, one cycle wide. A 1→0 transition (release) generates nothing.
- Request FSM states and transitions:
  - R_IDLE: a press event moves to R_PEND, sets req, and increments press_cnt (saturates at 255).
  - R_PEND: req = 1. Further presses merge into the pending request and do not increment press_cnt. ack = 1 clears req; the next state is R_COOL with the cooldown feature, otherwise R_IDLE.
  - R_COOL: busy = 1, and press events are discarded. After COOLDOWN_CYCLES cycles the FSM returns to R_IDLE.
- ack while req = 0 is ignored in every state.
- A press event and ack in the same cycle: ack wins, req clears, and the press is discarded. This holds in both configurations.
- A reset mid-debounce or mid-request discards all pending state; no request survives reset.

## Timing
- req latency: with bt_raw high and steady from edge 0, bt_clean rises at edge SYNC_STAGES + DEBOUNCE_CYCLES and req rises at edge SYNC_STAGES + DEBOUNCE_CYCLES + 1.
- Glitches shorter than DEBOUNCE_CYCLES cycles on bt_sync never change bt_clean.
- ack sampled high at edge k drops req after edge k.
- Cooldown: busy rises with that same edge and stays high for exactly COOLDOWN_CYCLES cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SEMAFORO_COOLDOWN_EN defined: the R_COOL state exists and busy behaves as described above.
- SEMAFORO_COOLDOWN_EN undefined:
  - R_COOL and its counter are not built, and busy is tied to 0;
  - ack returns the FSM to R_IDLE, so a new press is accepted on the very next press event.

## Structure
- Shared package semaforo_pkg holds:
  - the request FSM enum (R_IDLE, R_PEND, R_COOL);
  - the debounce FSM enum (D_STABLE, D_COUNT);
  - the light encodings (VERDE 3'b100, AMARELO 3'b010, VERMELHO 3'b001);
  - the press_cnt width constant (8).
- One sub-module, debounce_bt, contains the synchronizer and debounce counter and outputs bt_clean. The top level holds the request FSM, the cooldown logic and press_cnt.

## Test plan
- Reset: hold rst low with bt_raw high → all outputs 0. Release rst with bt_raw steady high (SYNC_STAGES = 2, DEBOUNCE_CYCLES = 4) → bt_clean = 1 at edge 6, req = 1 at edge 7, press_cnt = 1.
- Bounce: toggle bt_raw every 2 cycles for 20 cycles, then hold low → bt_clean, req and press_cnt stay 0.
- Merge: press, then a second clean press before any ack → req stays 1 and press_cnt = 1. Pulse ack → req = 0 on the next cycle.
- Cooldown (macro defined, COOLDOWN_CYCLES = 8):
  - ack → busy = 1 for exactly 8 cycles;
  - a press during busy leaves req = 0;
  - a press after busy falls → req = 1.
- Collision: a press event coincides with the ack edge → req = 0 and press_cnt unchanged. With the macro undefined, busy stays 0 throughout.
- Async reset while req = 1 with the debounce counter mid-count → req, bt_clean and busy drop immediately, without waiting for a clk edge. press_cnt = 0.
